// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the WISC instruction-fetch stage.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR    = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE  = 5'b00000;
  localparam logic        BUBBLE_VALID = 1'b0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; with neither asserted it holds.
module fetch_if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic [15:0]           instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] pc_plus2_i,
  output logic                  valid_o,
  output logic [15:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus2_o
);

  logic                  valid_q;
  logic [15:0]           instr_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_plus2_q;

  always_ff @(posedge clk) begin
    if (bubble_i) begin
      valid_q    <= BUBBLE_VALID;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus2_q <= '0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus2_q <= pc_plus2_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RUN/HALT FSM, redirect/stall/flush priority and IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_enable,
  output logic                  imem_wr,
  input  logic [15:0]           imem_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_id_valid,
  output logic [15:0]           if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus2,
  output logic                  halted,
  output logic                  err
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] pc_plus2;
  logic                  ifid_load;
  logic                  ifid_bubble;
  logic                  fetch_go;

  assign pc_plus2 = pc_q + ADDR_WIDTH'(2);

  // A "normal" edge: nothing of higher priority is claiming this cycle.
  assign fetch_go    = ~rst & ~redirect_valid & ~stall & ~flush;
  assign ifid_load   = fetch_go & (state_q == ST_RUN);
  assign ifid_bubble = rst | redirect_valid | (~stall & flush) | (fetch_go & (state_q == ST_HALT));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q    <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      state_q <= ST_RUN;
      if (redirect_pc[0]) err_q <= 1'b1;
    end else if (ifid_load) begin
      // HALT parks the PC on itself; it still enters IF/ID as a valid instruction.
      if (is_halt(imem_data)) state_q <= ST_HALT;
      else                    pc_q    <= pc_plus2;
    end
  end

  fetch_if_id_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_if_id (
    .clk        (clk),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (imem_data),
    .pc_i       (pc_q),
    .pc_plus2_i (pc_plus2),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_o       (if_id_pc),
    .pc_plus2_o (if_id_pc_plus2)
  );

  assign imem_addr   = pc_q;
  assign imem_enable = (state_q == ST_RUN) & ~rst & ~stall;
  assign imem_wr     = 1'b0;
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a small combinational instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  // 256-word memory indexed by addr[8:1]; default word 0x4000|index (never HALT).
  logic [15:0] mem [0:255];
  assign imem_data = mem[imem_addr[8:1]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_enable    (imem_enable),
    .imem_wr        (imem_wr),
    .imem_data      (imem_data),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .halted         (halted),
    .err            (err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                          input logic [15:0] pc, input logic [15:0] pc2);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(ins));
    chk({tag, ".pc"}, 32'(if_id_pc), 32'(pc));
    chk({tag, ".pc2"}, 32'(if_id_pc_plus2), 32'(pc2));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
    mem[0] = 16'h4001; mem[1] = 16'h4002; mem[2] = 16'h4003; mem[3] = 16'h0000;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset values
    tick(); tick();
    chk("rst.addr", 32'(imem_addr), 32'h0);
    chk("rst.en", 32'(imem_enable), 32'h0);
    chk("rst.wr", 32'(imem_wr), 32'h0);
    chk_ifid("rst.ifid", 1'b0, 16'h0800, 16'h0, 16'h0);
    chk("rst.halted", 32'(halted), 32'h0);
    chk("rst.err", 32'(err), 32'h0);

    // Straight-line fetch
    rst = 1'b0; #1;
    chk("run.en", 32'(imem_enable), 32'h1);
    tick(); chk_ifid("f0", 1'b1, 16'h4001, 16'h0, 16'h2);
    chk("f0.addr", 32'(imem_addr), 32'h2);
    tick(); chk_ifid("f2", 1'b1, 16'h4002, 16'h2, 16'h4);

    // Stall 3 cycles at pc 4
    stall = 1'b1; #1;
    chk("stall.en", 32'(imem_enable), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.pc", 32'(if_id_pc), 32'h2);
      chk("stall.addr", 32'(imem_addr), 32'h4);
    end
    stall = 1'b0;
    tick(); chk_ifid("f4", 1'b1, 16'h4003, 16'h4, 16'h6);

    // HALT at pc 6
    tick(); chk_ifid("halt", 1'b1, 16'h0000, 16'h6, 16'h8);
    chk("halt.halted", 32'(halted), 32'h1);
    chk("halt.addr", 32'(imem_addr), 32'h6);
    chk("halt.en", 32'(imem_enable), 32'h0);
    tick(); chk_ifid("halt.bub", 1'b0, 16'h0800, 16'h0, 16'h0);
    chk("halt.addr2", 32'(imem_addr), 32'h6);
    chk("halt.halted2", 32'(halted), 32'h1);

    // Redirect out of HALT
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick(); redirect_valid = 1'b0; #1;
    chk("rdh.halted", 32'(halted), 32'h0);
    chk("rdh.addr", 32'(imem_addr), 32'h40);
    chk("rdh.en", 32'(imem_enable), 32'h1);
    chk("rdh.valid", 32'(if_id_valid), 32'h0);
    tick(); chk_ifid("f40", 1'b1, 16'h4020, 16'h40, 16'h42);

    // Redirect with simultaneous stall
    redirect_valid = 1'b1; redirect_pc = 16'h0100; stall = 1'b1;
    tick(); redirect_valid = 1'b0; stall = 1'b0;
    chk("rds.valid", 32'(if_id_valid), 32'h0);
    chk("rds.addr", 32'(imem_addr), 32'h100);
    tick(); chk_ifid("f100", 1'b1, 16'h4080, 16'h100, 16'h102);

    // Flush: bubble, PC held
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("fl.valid", 32'(if_id_valid), 32'h0);
    chk("fl.addr", 32'(imem_addr), 32'h102);
    tick(); chk_ifid("f102", 1'b1, 16'h4081, 16'h102, 16'h104);

    // Misaligned redirect sets sticky err
    redirect_valid = 1'b1; redirect_pc = 16'h0103;
    tick(); redirect_valid = 1'b0;
    chk("mis.addr", 32'(imem_addr), 32'h102);
    chk("mis.err", 32'(err), 32'h1);
    tick(); chk("mis.pc", 32'(if_id_pc), 32'h102);
    chk("mis.err2", 32'(err), 32'h1);

    // Reset mid-run clears everything
    rst = 1'b1; #1;
    chk("rst2.en", 32'(imem_enable), 32'h0);
    tick();
    chk_ifid("rst2.ifid", 1'b0, 16'h0800, 16'h0, 16'h0);
    chk("rst2.addr", 32'(imem_addr), 32'h0);
    chk("rst2.err", 32'(err), 32'h0);
    chk("rst2.halted", 32'(halted), 32'h0);
    rst = 1'b0;
    tick(); chk_ifid("rst2.f0", 1'b1, 16'h4001, 16'h0, 16'h2);

    // Wrap at 0xFFFE
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick(); redirect_valid = 1'b0;
    chk("wrap.addr0", 32'(imem_addr), 32'hFFFE);
    tick(); chk_ifid("wrap", 1'b1, 16'h40FF, 16'hFFFE, 16'h0000);
    chk("wrap.addr", 32'(imem_addr), 32'h0);
    chk("wrap.err", 32'(err), 32'h0);
    tick(); chk_ifid("wrap.f0", 1'b1, 16'h4001, 16'h0, 16'h2);

    // Redirect in the same cycle HALT is fetched
    redirect_valid = 1'b1; redirect_pc = 16'h0006;
    tick(); redirect_pc = 16'h0010;
    chk("rhf.addr", 32'(imem_addr), 32'h6);
    tick(); redirect_valid = 1'b0;
    chk("rhf.halted", 32'(halted), 32'h0);
    chk("rhf.valid", 32'(if_id_valid), 32'h0);
    chk("rhf.addr2", 32'(imem_addr), 32'h10);
    tick(); chk_ifid("f10", 1'b1, 16'h4008, 16'h10, 16'h12);
    chk("f10.halted", 32'(halted), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-cycle/pipelined WISC datapath; sits directly upstream of the instruction memory and drives its address/enable. It holds the PC, advances it by 2 each fetch, and accepts branch/jump redirects from execute. It also honours stall and flush, detects HALT, and registers the fetched word into the IF/ID pipeline register consumed by decode.

## Interface
- ADDR_WIDTH, 16, PC and memory address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory; combinationally equals PC.
- imem_enable  output  1  memory read enable.
- imem_wr  output  1  tied to 0.
- imem_data  input  16  instruction word returned combinationally by memory.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  kill IF/ID contents (insert bubble).
- redirect_valid  input  1  taken branch/jump resolved.
- redirect_pc  input  ADDR_WIDTH  redirect target.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  16  registered instruction.
- if_id_pc  output  ADDR_WIDTH  address of if_id_instr.
- if_id_pc_plus2  output  ADDR_WIDTH  if_id_pc + 2.
- halted  output  1  fetch stopped on HALT.
- err  output  1  sticky: misaligned redirect seen.

## Operation
- States: RUN, HALT. Reset -> RUN.
- imem_enable = (state == RUN) & ~rst & ~stall. Memory is not read while rst is high (it loads its image then).
- Per-edge priority: rst > redirect_valid > stall > flush > normal fetch.
- rst: PC <= RESET_PC; IF/ID <= bubble; halted <= 0; err <= 0; state <= RUN.
- redirect_valid (either state, overrides stall): PC <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0}; IF/ID <= bubble; state <= RUN; halted <= 0. If redirect_pc[0] == 1, err <= 1 (sticky until rst).
- stall (no redirect): PC, IF/ID, state unchanged.
- flush (no redirect, no stall): IF/ID <= bubble; PC unchanged (same address refetched next cycle).
- Normal, RUN: IF/ID <= {valid=1, imem_data, PC, PC+2}. If imem_data[15:11] == 5'b00000 (HALT), PC unchanged, state <= HALT, halted <= 1; otherwise PC <= PC + 2.
- Normal, HALT: IF/ID <= bubble; PC unchanged; only redirect or rst exits.
- Bubble: valid=0, instr=16'h0800 (NOP), pc=0, pc_plus2=0.
- Arithmetic: PC + 2 modulo 2^ADDR_WIDTH; 16'hFFFE wraps to 16'h0000, no error. PC bit 0 is always 0.

## Timing
- Reset values: imem_addr=RESET_PC, imem_enable=0 during rst, imem_wr=0, if_id_valid=0, if_id_instr=16'h0800, if_id_pc=0, if_id_pc_plus2=0, halted=0, err=0.
- Fetch latency: word at PC in cycle N appears on if_id_* in cycle N+1.
- Redirect asserted cycle N: imem_addr = target in N+1; target instruction valid in IF/ID in N+2; one bubble in IF/ID in N+1.
- Redirect and stall together: redirect wins; stall ignored that cycle.
- Redirect arriving in the same cycle a HALT is fetched: redirect wins, HALT discarded, state stays RUN.
- halted rises the edge HALT is latched into IF/ID; HALT itself reaches decode with valid=1.
- rst asserted mid-operation: all in-flight state discarded on that edge; first fetch from RESET_PC the cycle after rst falls.

## Structure
- Shared package fetch_pkg: NOP_INSTR = 16'h0800, HALT_OPCODE = 5'b00000, state encoding (RUN, HALT), bubble field values.
- One sub-module, fetch_if_id_reg: IF/ID register with load, bubble and hold controls; fetch_stage holds PC, FSM and priority logic.

## Test plan
- Reset then run with memory 0x0000..0x0006 = 16'h4001,16'h4002,16'h4003,16'h0000 -> IF/ID sequence pc 0,2,4,6; halted=1 after pc 6 latched; PC stays 6; following IF/ID bubbles.
- Stall for 3 cycles at pc 4 -> imem_enable=0, if_id_pc=2 held 3 cycles, then pc 4 with same instr.
- redirect_valid with redirect_pc=16'h0100 at pc 8 -> one bubble, then if_id_pc=16'h0100; redirect+stall same cycle -> redirect taken.
- redirect_pc=16'h0103 -> PC=16'h0102, err=1 and stays 1 until rst.
- PC at 16'hFFFE, non-HALT word -> next PC 16'h0000, if_id_pc_plus2=16'h0000, err=0.
- In HALT, redirect to 16'h0040 -> halted=0, fetch resumes at 16'h0040; rst mid-run -> outputs return to reset values, fetch restarts at RESET_PC.
